tconv_zero_upsampler: RTL and testbench
=======================================

Name: tconv_zero_upsampler

Overview:
- Streaming zero-insertion / border-padding front end for the transposed-conv layers (trans_conv2d_4x4_layer and its successors).
- Takes a row-major IN_WIDTH x IN_HEIGHT feature map, CHANNELS lanes in parallel, and emits the dilated, padded frame the conv core consumes.
- Full valid/ready flow control replaces fixed inter-pixel gaps; emits frame/line markers.
- Geometry is fully parametrised: stride, border pad, size and lane count.

Parameters:
- DATA_WIDTH, 16, signed bits per channel sample
- CHANNELS, 1, parallel channel lanes packed in one beat, lane 0 at LSBs
- IN_WIDTH, 13, input pixels per row (>=1)
- IN_HEIGHT, 13, input rows per frame (>=1)
- STRIDE, 2, output spacing between input pixels (>=1); STRIDE-1 zeros inserted
- PAD, 2, zero pixels/rows on each border (>=0); kernel K, conv padding P gives PAD = K-1-P
- Derived: OW = (IN_WIDTH-1)*STRIDE+1+2*PAD; OH = (IN_HEIGHT-1)*STRIDE+1+2*PAD

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  DATA_WIDTH*CHANNELS  input pixel, all lanes
- out_valid  out  1  output beat present (registered)
- out_ready  in  1  downstream accepts
- out_data  out  DATA_WIDTH*CHANNELS  pixel or zeros (registered)
- out_sof  out  1  first beat of frame (x=0,y=0)
- out_eol  out  1  last beat of each output row (x=OW-1)
- out_eof  out  1  last beat of frame (x=OW-1,y=OH-1)
- busy  out  1  high while state != IDLE or out_valid

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_sof/eol/eof=0, busy=0, in_ready=0, counters=0, state=IDLE. A partial frame is discarded and the next frame starts clean.
- Output stage: a single register. It loads when load_en = out_valid==0 || out_ready==1. While out_valid && !out_ready, out_data and flags hold stable.
- States:
  - IDLE: in_ready=0. Move to RUN when in_valid=1. No input is consumed on the transition cycle.
  - RUN: walk (x,y) over OW x OH in row-major order.
  - DRAIN: wait for the final beat to be accepted, then return to IDLE.
- Data position: x>=PAD, y>=PAD, (x-PAD)%STRIDE==0, (y-PAD)%STRIDE==0, x<PAD+(IN_WIDTH-1)*STRIDE+1, same rule in y. Tracked with phase counters; no division.
- At a data position in RUN:
  - in_ready = load_en (combinational).
  - On accept, out_data<=in_data, out_valid<=1, then (x,y) advances.
  - If in_valid=0, nothing advances and out_valid clears once the held beat is taken.
- At a zero position in RUN: in_ready=0. When load_en=1, out_data<=0, out_valid<=1, (x,y) advances.
- Latency: 1 cycle from input accept, or zero-beat generation, to out_valid. Sustained throughput is 1 beat/cycle with out_ready=1 and in_valid held.
- Flags are registered alongside out_data from the (x,y) of that beat.
- After loading (OW-1,OH-1), go to DRAIN. Once it is accepted, go to IDLE. A new frame cannot start on the same cycle.
- Input count: exactly IN_WIDTH*IN_HEIGHT accepts per frame. The block never accepts input in IDLE or DRAIN.
- Widths: x counter clog2(OW), y counter clog2(OH), phase counters clog2(STRIDE) (min 1 bit). Values pass through unchanged; no arithmetic on data.
- STRIDE=1, PAD=0: pure registered pass-through with flags.
- IN_WIDTH=1: each data row has a single data beat at x=PAD.

Decomposition:
- Shared package figan_pkg holds:
  - DATA_WIDTH default
  - state enum typedef (IDLE/RUN/DRAIN)
  - a constant function for output dimension from (in, stride, pad)
- One sub-module, tconv_axis_phase_cnt: a 1-D position counter with pad/stride phase tracking. It outputs pos, is_data, is_last, is_last_data, and is instantiated for x and for y (y advances on x is_last).

Test Plan:
- 3x3 input 1..9, STRIDE=2, PAD=1, out_ready=1, in_valid=1:
  - 49 beats; nonzero at beat indices 8,10,12,22,24,26,36,38,40 with values 1..9, all others 0.
  - sof on beat 0, eol on beats 6,13,...,48, eof on beat 48.
- Default params, 13x13 ramp input:
  - 841 beats; 169 nonzero beats equal to the inputs in order.
  - First nonzero at beat 2*29+2=60; next input accepted only at beat 62.
- Same 3x3 case, out_ready toggled with a 1-high/2-low pattern and in_valid random:
  - Identical beat sequence to the first case.
  - out_data stable while stalled; no input lost or duplicated.
- STRIDE=1, PAD=0, CHANNELS=4, 2x2 input:
  - 4 beats equal to the inputs, 1-cycle latency.
  - eol on beats 1 and 3, eof on beat 3.
- rst asserted after 20 output beats of the first case:
  - out_valid=0 and in_ready=0 immediately, asynchronously.
  - A following full frame reproduces the complete 49-beat sequence starting with sof.
- Two back-to-back frames:
  - busy stays high through each frame and falls for at least 1 cycle between them.
  - Second frame's sof arrives after the first frame's eof is accepted.

Source files
------------

// File: rtl/figan_pkg.sv
// Shared definitions for the transposed-conv front end: default sample width,
// controller state encoding and the dilated/padded output dimension.
package figan_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // One output axis length: in_len samples spread by stride, plus pad on both sides.
  function automatic int out_dim(input int in_len, input int stride, input int pad);
    return (in_len - 1) * stride + 1 + 2 * pad;
  endfunction

endpackage

// File: rtl/tconv_zero_upsampler_if.sv
// Stream bundle for the zero upsampler: input beat handshake plus output beat
// handshake with frame/line markers.
interface tconv_zero_upsampler_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_sof;
  logic         out_eol;
  logic         out_eof;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sof, out_eol, out_eof
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sof, out_eol, out_eof
  );
endinterface

// File: rtl/tconv_axis_phase_cnt.sv
// One axis of the output walk: position counter plus a stride phase that is only
// live inside the data region, so data positions are found without division.
module tconv_axis_phase_cnt
  import figan_pkg::*;
#(
  parameter int IN_LEN = 13,
  parameter int STRIDE = 2,
  parameter int PAD    = 2,
  parameter int POS_W  = (out_dim(IN_LEN, STRIDE, PAD) > 1) ? $clog2(out_dim(IN_LEN, STRIDE, PAD)) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  output logic [POS_W-1:0] pos,
  output logic             is_data,
  output logic             is_last,
  output logic             is_last_data
);
  localparam int LEN  = out_dim(IN_LEN, STRIDE, PAD);
  localparam int PH_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [POS_W-1:0] LAST_POS      = POS_W'(LEN - 1);
  localparam logic [POS_W-1:0] PAD_POS       = POS_W'(PAD);
  localparam logic [POS_W-1:0] LAST_DATA_POS = POS_W'(PAD + (IN_LEN - 1) * STRIDE);
  localparam logic [PH_W-1:0]  PH_LAST       = PH_W'(STRIDE - 1);
  localparam logic             RGN_AT_ZERO   = (PAD == 0);

  logic [PH_W-1:0]  phase;
  logic             in_rgn;
  logic [POS_W-1:0] pos_nxt;

  assign pos_nxt      = pos + 1'b1;
  assign is_last      = (pos == LAST_POS);
  assign is_data      = in_rgn && (phase == '0);
  assign is_last_data = is_data && (pos == LAST_DATA_POS);

  // in_rgn covers [PAD, LAST_DATA_POS]; phase counts stride slots within it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos    <= '0;
      phase  <= '0;
      in_rgn <= RGN_AT_ZERO;
    end else if (adv) begin
      if (is_last) begin
        pos    <= '0;
        phase  <= '0;
        in_rgn <= RGN_AT_ZERO;
      end else begin
        pos    <= pos_nxt;
        phase  <= (in_rgn && phase != PH_LAST) ? phase + 1'b1 : '0;
        in_rgn <= in_rgn ? (pos != LAST_DATA_POS) : (pos_nxt == PAD_POS);
      end
    end
  end

endmodule

// File: rtl/tconv_zero_upsampler.sv
// Streaming zero-insertion and border padding ahead of the transposed-conv core:
// walks the dilated, padded frame and emits input pixels or zero beats.
module tconv_zero_upsampler
  import figan_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CHANNELS   = 1,
  parameter int IN_WIDTH   = 13,
  parameter int IN_HEIGHT  = 13,
  parameter int STRIDE     = 2,
  parameter int PAD        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  tconv_zero_upsampler_if.slave io,
  output logic                  busy
);
  localparam int OW = out_dim(IN_WIDTH, STRIDE, PAD);
  localparam int OH = out_dim(IN_HEIGHT, STRIDE, PAD);
  localparam int XW = (OW > 1) ? $clog2(OW) : 1;
  localparam int YW = (OH > 1) ? $clog2(OH) : 1;
  localparam logic [DATA_WIDTH*CHANNELS-1:0] ZERO_BEAT = '0;

  state_e        state;
  logic [XW-1:0] x_pos;
  logic [YW-1:0] y_pos;
  logic          x_data, y_data, x_last, y_last;
  logic          x_last_data_unused, y_last_data_unused;
  logic          at_data, load_en, adv, frame_last;

  tconv_axis_phase_cnt #(.IN_LEN(IN_WIDTH), .STRIDE(STRIDE), .PAD(PAD), .POS_W(XW)) u_x (
    .clk          (clk),
    .rst          (rst),
    .adv          (adv),
    .pos          (x_pos),
    .is_data      (x_data),
    .is_last      (x_last),
    .is_last_data (x_last_data_unused)
  );

  tconv_axis_phase_cnt #(.IN_LEN(IN_HEIGHT), .STRIDE(STRIDE), .PAD(PAD), .POS_W(YW)) u_y (
    .clk          (clk),
    .rst          (rst),
    .adv          (adv && x_last),
    .pos          (y_pos),
    .is_data      (y_data),
    .is_last      (y_last),
    .is_last_data (y_last_data_unused)
  );

  // A zero position advances whenever the output register can load; a data
  // position additionally needs an input beat.
  assign at_data     = x_data && y_data;
  assign load_en     = !io.out_valid || io.out_ready;
  assign adv         = (state == RUN) && load_en && (!at_data || io.in_valid);
  assign frame_last  = x_last && y_last;
  assign io.in_ready = (state == RUN) && at_data && load_en;
  assign busy        = (state != IDLE) || io.out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      io.out_valid <= 1'b0;
      io.out_data  <= ZERO_BEAT;
      io.out_sof   <= 1'b0;
      io.out_eol   <= 1'b0;
      io.out_eof   <= 1'b0;
    end else begin
      unique case (state)
        IDLE:    if (io.in_valid) state <= RUN;
        RUN:     if (adv && frame_last) state <= DRAIN;
        DRAIN:   if (io.out_valid && io.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase

      // Output register stage: load a new beat, or retire the accepted one.
      if (adv) begin
        io.out_valid <= 1'b1;
        io.out_data  <= at_data ? io.in_data : ZERO_BEAT;
        io.out_sof   <= (x_pos == '0) && (y_pos == '0);
        io.out_eol   <= x_last;
        io.out_eof   <= frame_last;
      end else if (io.out_ready) begin
        io.out_valid <= 1'b0;
        io.out_sof   <= 1'b0;
        io.out_eol   <= 1'b0;
        io.out_eof   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tconv_zero_upsampler.sv
// Bench for tconv_zero_upsampler: three geometries behind one shared stimulus
// driver, checked against a coordinate-walk reference model.
module tb_tconv_zero_upsampler;

  typedef struct {
    logic [63:0] data;
    logic [2:0]  flg;   // {sof, eol, eof}
    int          t;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  int          sel;
  logic        t_in_valid, t_out_ready;
  logic [63:0] t_in_data;
  logic        busy_a, busy_b, busy_c;

  always #5 clk = ~clk;

  tconv_zero_upsampler_if #(.W(16)) ifa ();
  tconv_zero_upsampler_if #(.W(64)) ifb ();
  tconv_zero_upsampler_if #(.W(16)) ifc ();

  assign ifa.in_valid  = t_in_valid && (sel == 0);
  assign ifa.in_data   = t_in_data[15:0];
  assign ifa.out_ready = (sel == 0) ? t_out_ready : 1'b1;
  assign ifb.in_valid  = t_in_valid && (sel == 1);
  assign ifb.in_data   = t_in_data;
  assign ifb.out_ready = (sel == 1) ? t_out_ready : 1'b1;
  assign ifc.in_valid  = t_in_valid && (sel == 2);
  assign ifc.in_data   = t_in_data[15:0];
  assign ifc.out_ready = (sel == 2) ? t_out_ready : 1'b1;

  tconv_zero_upsampler #(.DATA_WIDTH(16), .CHANNELS(1), .IN_WIDTH(3), .IN_HEIGHT(3),
                         .STRIDE(2), .PAD(1)) dut_a (
    .clk(clk), .rst(rst), .io(ifa), .busy(busy_a));

  tconv_zero_upsampler #(.DATA_WIDTH(16), .CHANNELS(4), .IN_WIDTH(2), .IN_HEIGHT(2),
                         .STRIDE(1), .PAD(0)) dut_b (
    .clk(clk), .rst(rst), .io(ifb), .busy(busy_b));

  tconv_zero_upsampler dut_c (
    .clk(clk), .rst(rst), .io(ifc), .busy(busy_c));

  logic        m_ov, m_ir, m_busy;
  logic [63:0] m_od;
  logic [2:0]  m_flg;

  always_comb begin
    m_ov   = ifa.out_valid;
    m_ir   = ifa.in_ready;
    m_busy = busy_a;
    m_od   = {48'd0, ifa.out_data};
    m_flg  = {ifa.out_sof, ifa.out_eol, ifa.out_eof};
    if (sel == 1) begin
      m_ov   = ifb.out_valid;
      m_ir   = ifb.in_ready;
      m_busy = busy_b;
      m_od   = ifb.out_data;
      m_flg  = {ifb.out_sof, ifb.out_eol, ifb.out_eof};
    end else if (sel == 2) begin
      m_ov   = ifc.out_valid;
      m_ir   = ifc.in_ready;
      m_busy = busy_c;
      m_od   = {48'd0, ifc.out_data};
      m_flg  = {ifc.out_sof, ifc.out_eol, ifc.out_eof};
    end
  end

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          in_idx;
  beat_t       got_q[$];
  beat_t       exp_q[$];
  int          acc_q[$];
  logic [63:0] in_q[$];
  bit          busy_mem[0:8191];
  bit          stall_prev = 1'b0;
  logic [63:0] held_d;
  logic [2:0]  held_f;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: beats handed over at the next edge, busy history, stall hold.
  always @(negedge clk) begin
    busy_mem[cyc % 8192] <= m_busy;
    if (!rst && m_ov && t_out_ready) got_q.push_back('{m_od, m_flg, cyc});
    if (!rst && stall_prev) begin
      chk("stall_data", m_od, held_d);
      chk("stall_flags", 64'(m_flg), 64'(held_f));
    end
    stall_prev <= !rst && m_ov && !t_out_ready;
    held_d     <= m_od;
    held_f     <= m_flg;
  end

  // Reference: walk every output coordinate, place inputs on the stride grid.
  task automatic build_model(input int iw, input int ih, input int s, input int p, input int nf);
    int    ow, oh, k;
    bit    isd;
    beat_t b;
    ow = (iw - 1) * s + 1 + 2 * p;
    oh = (ih - 1) * s + 1 + 2 * p;
    k  = 0;
    exp_q.delete();
    for (int f = 0; f < nf; f++)
      for (int y = 0; y < oh; y++)
        for (int x = 0; x < ow; x++) begin
          isd = (x >= p) && (y >= p) && ((x - p) % s == 0) && ((y - p) % s == 0) &&
                (x <= p + (iw - 1) * s) && (y <= p + (ih - 1) * s);
          b.data = isd ? in_q[k] : 64'd0;
          if (isd) k++;
          b.flg = {(x == 0) && (y == 0), x == ow - 1, (x == ow - 1) && (y == oh - 1)};
          b.t   = 0;
          exp_q.push_back(b);
        end
  endtask

  task automatic compare_frames(input string tag);
    int n;
    chk($sformatf("%s_count", tag), 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data[%0d]", tag, i), got_q[i].data, exp_q[i].data);
      chk($sformatf("%s_flags[%0d]", tag, i), 64'(got_q[i].flg), 64'(exp_q[i].flg));
    end
  endtask

  task automatic run(input int stop, input int rdy_mode, input int vld_mode, input int budget);
    int n;
    n = 0;
    got_q.delete();
    acc_q.delete();
    in_idx = 0;
    while (got_q.size() < stop && n < budget) begin
      @(posedge clk);
      #1;
      t_in_valid  = (in_idx < in_q.size()) && (vld_mode == 0 || $urandom_range(0, 1) == 1);
      t_in_data   = (in_idx < in_q.size()) ? in_q[in_idx] : 64'd0;
      t_out_ready = (rdy_mode == 0) || (cyc % 3 == 0);
      @(negedge clk);
      if (t_in_valid && m_ir) begin
        acc_q.push_back(cyc);
        in_idx++;
      end
      n++;
    end
    @(posedge clk);
    #1;
    chk("run_within_budget", 64'(got_q.size() >= stop), 64'd1);
    t_in_valid  = 1'b0;
    t_out_ready = 1'b1;
  endtask

  initial begin
    int c1, c2, low, hi_err, fnz, snz;
    rst = 1'b1;
    sel = 0;
    t_in_valid = 1'b0;
    t_out_ready = 1'b1;
    t_in_data = 64'd0;
    #12;
    chk("rst_out_valid", 64'(m_ov), 64'd0);
    chk("rst_in_ready", 64'(m_ir), 64'd0);
    chk("rst_busy", 64'(m_busy), 64'd0);
    chk("rst_out_data", m_od, 64'd0);
    chk("rst_flags", 64'(m_flg), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 3x3 ramp, free flowing
    in_q.delete();
    for (int i = 1; i <= 9; i++) in_q.push_back(64'(i));
    build_model(3, 3, 2, 1, 1);
    run(49, 0, 0, 500);
    compare_frames("a_plain");
    chk("a_plain_accepts", 64'(in_idx), 64'd9);

    // same frame with 1-high/2-low backpressure and random input gaps
    run(49, 1, 1, 3000);
    compare_frames("a_stall");
    chk("a_stall_accepts", 64'(in_idx), 64'd9);

    // async reset after 20 beats, then a clean random frame
    in_q.delete();
    for (int i = 0; i < 9; i++) in_q.push_back(64'($urandom_range(0, 65535)));
    build_model(3, 3, 2, 1, 1);
    run(20, 0, 0, 500);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(m_ov), 64'd0);
    chk("midrst_in_ready", 64'(m_ir), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 64'(m_busy), 64'd0);
    run(49, 0, 0, 500);
    compare_frames("a_after_rst");

    // two frames back to back with input held valid
    in_q.delete();
    for (int i = 0; i < 18; i++) in_q.push_back(64'($urandom_range(1, 65535)));
    build_model(3, 3, 2, 1, 2);
    run(98, 0, 0, 1000);
    compare_frames("a_b2b");
    if (got_q.size() >= 98) begin
      c1 = got_q[48].t;
      c2 = got_q[49].t;
      chk("b2b_sof_after_eof", 64'(c2 > c1), 64'd1);
      low = 0;
      for (int i = c1 + 1; i < c2; i++) if (!busy_mem[i % 8192]) low++;
      chk("b2b_busy_gap", 64'(low >= 1), 64'd1);
      hi_err = 0;
      for (int i = got_q[0].t; i <= c1; i++) if (!busy_mem[i % 8192]) hi_err++;
      for (int i = c2; i <= got_q[97].t; i++) if (!busy_mem[i % 8192]) hi_err++;
      chk("b2b_busy_in_frame", 64'(hi_err), 64'd0);
    end

    // stride 1, no pad, four lanes: registered pass-through
    sel = 1;
    in_q.delete();
    for (int i = 0; i < 4; i++) in_q.push_back({$urandom, $urandom});
    build_model(2, 2, 1, 0, 1);
    run(4, 0, 0, 100);
    compare_frames("b_pass");
    for (int i = 0; i < 4; i++)
      if (i < got_q.size() && i < acc_q.size())
        chk($sformatf("b_latency[%0d]", i), 64'(got_q[i].t), 64'(acc_q[i] + 1));

    // default geometry, 13x13 ramp
    sel = 2;
    in_q.delete();
    for (int i = 1; i <= 169; i++) in_q.push_back(64'(i));
    build_model(13, 13, 2, 2, 1);
    run(841, 0, 0, 3000);
    compare_frames("c_default");
    fnz = -1;
    snz = -1;
    for (int i = 0; i < got_q.size(); i++)
      if (got_q[i].data != 64'd0) begin
        if (fnz < 0) fnz = i;
        else if (snz < 0) snz = i;
      end
    chk("c_first_data_beat", 64'(fnz), 64'd60);
    chk("c_second_data_beat", 64'(snz), 64'd62);
    if (fnz >= 0 && acc_q.size() > 0)
      chk("c_first_latency", 64'(got_q[fnz].t), 64'(acc_q[0] + 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
